hough_peak_finder: RTL

Scans the Hough accumulator memory once per frame, picks (r, phi) cells whose vote count reaches a runtime threshold and, when enabled, is a local maximum along r. Each accepted cell is written into the downstream (r, phi) peak queue through its en/rw write port. The block sits between the vote accumulator RAM and the peak queue. It stops after a fixed number of peaks so the queue is never overrun.

---
 rtl/hough_pkg.sv | 28 ++
 rtl/nms_window.sv | 68 ++++++
 rtl/hough_peak_finder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hough_pkg.sv
// hough_pkg: shared widths, geometry defaults, FSM state and peak record for
// the Hough peak finder.
package hough_pkg;

    localparam int unsigned msb_r     = 11;
    localparam int unsigned msb_phi   = 7;
    localparam int unsigned msb_vote  = 9;
    localparam int unsigned msb_addr  = 17;
    localparam int unsigned msb_cnt   = 2;

    localparam int unsigned N_R       = 1024;
    localparam int unsigned N_PHI     = 180;
    localparam int unsigned MAX_PEAKS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One (r, phi) cell coordinate as it travels down the read pipeline.
    typedef struct packed {
        logic [msb_phi:0] phi;
        logic [msb_r:0]   r;
    } peak_t;

endpackage

// File: rtl/nms_window.sv
// nms_window: vote window along r with row-edge zero-forcing and the peak test.
// With HOUGH_PEAK_NMS_EN defined, a cell is a peak when it reaches the
// threshold, beats its left neighbour and is not beaten by its right one.
// Without it, only the threshold applies and cur is kept purely as a delay
// stage so the push latency does not change.
module nms_window
    import hough_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [msb_vote:0] vote_in,
    input  logic              next_valid,
    input  logic              at_first,
    input  logic              at_last,
    input  logic [msb_vote:0] thresh,
    output logic              peak_c
);

`ifdef HOUGH_PEAK_NMS_EN

    logic [msb_vote:0] cur;
    logic [msb_vote:0] prev;
    logic [msb_vote:0] prev_eff;
    logic [msb_vote:0] next_eff;

    // Shift the vote stream through the cur/prev taps; next is the live read data.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cur  <= '0;
            prev <= '0;
        end else begin
            prev <= cur;
            cur  <= vote_in;
        end
    end

    // Zero taps that fall outside the current row, then test for a local maximum.
    always_comb begin
        prev_eff = at_first ? '0 : prev;
        next_eff = (at_last || !next_valid) ? '0 : vote_in;
        peak_c   = (cur >= thresh) && (cur > prev_eff) && (cur >= next_eff);
    end

`else

    logic [msb_vote:0] cur;
    logic              unused_taps;

    // Single delay stage that stands in for the window.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cur <= '0;
        end else begin
            cur <= vote_in;
        end
    end

    assign unused_taps = ^{next_valid, at_first, at_last};

    // Plain threshold test.
    always_comb begin
        peak_c = (cur >= thresh);
    end

`endif

endmodule

// File: rtl/hough_peak_finder.sv
// hough_peak_finder: scans the Hough accumulator once per start, pushes cells
// that pass the peak test into the (r, phi) peak queue, and stops early after
// MAX_PEAKS pushes. Macro HOUGH_PEAK_NMS_EN enables 3-point non-maximum
// suppression along r (see nms_window). Index/vote/address widths come from
// hough_pkg.
module hough_peak_finder #(
    parameter int unsigned N_R       = hough_pkg::N_R,
    parameter int unsigned N_PHI     = hough_pkg::N_PHI,
    parameter int unsigned MAX_PEAKS = hough_pkg::MAX_PEAKS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [hough_pkg::msb_vote:0] thresh,
    output logic [hough_pkg::msb_addr:0] acc_addr,
    input  logic [hough_pkg::msb_vote:0] acc_data,
    output logic [hough_pkg::msb_r:0]    r_out,
    output logic [hough_pkg::msb_phi:0]  phi_out,
    output logic                        q_en,
    output logic                        q_rw,
    output logic                        busy,
    output logic                        done,
    output logic [hough_pkg::msb_cnt:0]  peak_cnt
);
    import hough_pkg::*;

    localparam int unsigned R_W    = msb_r + 1;
    localparam int unsigned PHI_W  = msb_phi + 1;
    localparam int unsigned VOTE_W = msb_vote + 1;
    localparam int unsigned ADDR_W = msb_addr + 1;
    localparam int unsigned CNT_W  = msb_cnt + 1;

    state_t              state;
    state_t              state_next;

    peak_t               cell_a;      // cell whose address is on acc_addr
    peak_t               cell_b;      // cell whose data is on acc_data
    peak_t               cell_c;      // cell held in the window's cur tap
    logic                valid_b;
    logic                valid_c;

    logic [VOTE_W-1:0]   thresh_q;
    logic                drain_cnt;

    logic                start_ok;
    logic                last_addr;
    logic                at_first;
    logic                at_last;
    logic                peak_c;
    logic                push;
    logic                cap;

    // Accept, end-of-scan, row-edge, push and cap decodes.
    always_comb begin
        start_ok  = start && (state == IDLE) && !done;
        last_addr = (cell_a.r == R_W'(N_R - 1)) && (cell_a.phi == PHI_W'(N_PHI - 1));
        at_first  = (cell_c.r == '0);
        at_last   = (cell_c.r == R_W'(N_R - 1));
        push      = valid_c && peak_c && ((state == SCAN) || (state == DRAIN));
        cap       = push && (peak_cnt == CNT_W'(MAX_PEAKS - 1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; reaching the peak cap jumps straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) state_next = SCAN;
            end
            SCAN: begin
                if (cap)            state_next = DONE;
                else if (last_addr) state_next = DRAIN;
            end
            DRAIN: begin
                if (cap || drain_cnt) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Two-cycle drain timer for the read and next-tap stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end else begin
            drain_cnt <= 1'b0;
        end
    end

    // Address and r/phi counters, r fastest; frozen once SCAN is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_addr <= '0;
            cell_a   <= '0;
        end else if (start_ok) begin
            acc_addr <= '0;
            cell_a   <= '0;
        end else if ((state == SCAN) && (state_next == SCAN)) begin
            acc_addr <= acc_addr + ADDR_W'(1);
            if (cell_a.r == R_W'(N_R - 1)) begin
                cell_a.r   <= '0;
                cell_a.phi <= cell_a.phi + PHI_W'(1);
            end else begin
                cell_a.r   <= cell_a.r + R_W'(1);
            end
        end
    end

    // Coordinate pipeline alongside the read data; cleared on a new scan.
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            cell_b  <= '0;
            cell_c  <= '0;
            valid_b <= 1'b0;
            valid_c <= 1'b0;
        end else begin
            cell_b  <= cell_a;
            valid_b <= (state == SCAN);
            cell_c  <= cell_b;
            valid_c <= valid_b;
        end
    end

    // Threshold is captured once per scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_q <= '0;
        end else if (start_ok) begin
            thresh_q <= thresh;
        end
    end

    nms_window u_nms_window (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .vote_in    (acc_data),
        .next_valid (valid_b),
        .at_first   (at_first),
        .at_last    (at_last),
        .thresh     (thresh_q),
        .peak_c     (peak_c)
    );

    // Registered queue write, status and peak counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= '0;
            phi_out  <= '0;
            q_en     <= 1'b0;
            q_rw     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            peak_cnt <= '0;
        end else begin
            q_en <= push;
            q_rw <= push;
            done <= (state == DONE);
            if (push) begin
                r_out   <= cell_c.r;
                phi_out <= cell_c.phi;
            end
            if (start_ok) begin
                busy <= 1'b1;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
            if (start_ok) begin
                peak_cnt <= '0;
            end else if (push) begin
                peak_cnt <= peak_cnt + CNT_W'(1);
            end
        end
    end

endmodule
